// File: rtl/mem_rd_pkg.sv
// Shared types and helpers for the BRAM frame reader.
//   scale_mode_t : latched zoom mode (1x / 2x pixel replication)
//   pipe_tag_t   : per-request tag carried alongside the BRAM read latency
//   fb_size      : words per frame buffer
package mem_rd_pkg;

  typedef enum logic {
    SCALE_1X = 1'b0,
    SCALE_2X = 1'b1
  } scale_mode_t;

  typedef struct packed {
    logic en;
    logic sof;
    logic eol;
  } pipe_tag_t;

  // Words occupied by one frame buffer; buffer k starts at k*fb_size.
  function automatic int unsigned fb_size(input int unsigned cols, input int unsigned rows);
    return cols * rows;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Fixed-depth shift register for request tags, matching the BRAM read latency.
//   clk, rst : clock, synchronous active-high clear
//   din      : tag entering with the request
//   dout     : tag emerging DEPTH cycles later
module mem_rd_pipe
  import mem_rd_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  pipe_tag_t din,
  output pipe_tag_t dout
);

  pipe_tag_t [DEPTH-1:0] stage;

  if (DEPTH == 1) begin : g_one
    always_ff @(posedge clk) begin
      if (rst) stage[0] <= '0;
      else     stage[0] <= din;
    end
  end else begin : g_multi
    always_ff @(posedge clk) begin
      if (rst) stage <= '0;
      else     stage <= {stage[DEPTH-2:0], din};
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/mem_rd_ctr.sv
// BRAM port-B frame reader for the VGA pixel path, with page-flip buffers
// and 1x/2x pixel-replication zoom.
//   clk, rst          : clock, synchronous active-high reset
//   enb_o/web_o       : BRAM enable (= pixel request) / write enable (tied 0)
//   addrb_o           : registered address of the current pixel
//   d2memb_o          : BRAM write data (tied 0)
//   mem2db_i          : BRAM read data
//   bram_en_i         : one pulse per displayed pixel from VGA timing
//   fb_swap_i         : request to show the next buffer from the next frame
//   scale_i           : zoom mode, sampled at frame end
//   fb_sel_o          : buffer currently being read
//   RGB_o/RGB_en_o    : pixel data / valid, aligned to BRAM latency
//   sof_o/eol_o       : first pixel of frame / last pixel of line
module mem_rd_ctr
  import mem_rd_pkg::*;
#(
  parameter int unsigned MAX_COL = 540,
  parameter int unsigned MAX_ROW = 540,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned NUM_FB  = 2,
  parameter int unsigned RD_LAT  = 2,
  localparam int unsigned FB_SEL_W = (NUM_FB > 1) ? $clog2(NUM_FB) : 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic                enb_o,
  output logic                web_o,
  output logic [ADDR_W-1:0]   addrb_o,
  output logic [DATA_W-1:0]   d2memb_o,
  input  logic [DATA_W-1:0]   mem2db_i,
  input  logic                bram_en_i,
  input  logic                fb_swap_i,
  input  logic                scale_i,
  output logic [FB_SEL_W-1:0] fb_sel_o,
  output logic [DATA_W-1:0]   RGB_o,
  output logic                RGB_en_o,
  output logic                sof_o,
  output logic                eol_o
);

  localparam int unsigned COL_W = (MAX_COL > 1) ? $clog2(MAX_COL) : 1;
  localparam int unsigned ROW_W = (MAX_ROW > 1) ? $clog2(MAX_ROW) : 1;
  localparam logic [COL_W-1:0]    COL_LAST  = COL_W'(MAX_COL - 1);
  localparam logic [ROW_W-1:0]    ROW_LAST  = ROW_W'(MAX_ROW - 1);
  localparam logic [FB_SEL_W-1:0] FB_LAST   = FB_SEL_W'(NUM_FB - 1);
  localparam logic [ADDR_W-1:0]   LINE_STEP = ADDR_W'(MAX_COL);
  localparam logic [ADDR_W-1:0]   FB_STEP   = ADDR_W'(fb_size(MAX_COL, MAX_ROW));

  logic [COL_W-1:0]  out_col, nxt_col, nxt_src;
  logic [ROW_W-1:0]  out_row, nxt_row;
  logic [ADDR_W-1:0] line_base, nxt_line;
  logic [ADDR_W-1:0] fb_base, nxt_fb_base;
  logic [FB_SEL_W-1:0] nxt_fb_sel;
  logic              swap_pend;
  scale_mode_t       scale_mode, nxt_scale;
  logic              line_end, frame_end;
  pipe_tag_t         tag_in, tag_out;

  assign enb_o    = bram_en_i;
  assign web_o    = 1'b0;
  assign d2memb_o = '0;

  assign line_end  = (out_col == COL_LAST);
  assign frame_end = line_end && (out_row == ROW_LAST);

  // Position, line base and buffer after the current request.
  always_comb begin
    nxt_col     = out_col + COL_W'(1);
    nxt_row     = out_row;
    nxt_line    = line_base;
    nxt_fb_base = fb_base;
    nxt_fb_sel  = fb_sel_o;
    nxt_scale   = scale_mode;
    if (frame_end) begin
      nxt_col   = '0;
      nxt_row   = '0;
      nxt_line  = '0;
      nxt_scale = scale_i ? SCALE_2X : SCALE_1X;
      if (swap_pend || fb_swap_i) begin
        if (fb_sel_o == FB_LAST) begin
          nxt_fb_sel  = '0;
          nxt_fb_base = '0;
        end else begin
          nxt_fb_sel  = fb_sel_o + FB_SEL_W'(1);
          nxt_fb_base = fb_base + FB_STEP;
        end
      end
    end else if (line_end) begin
      nxt_col = '0;
      nxt_row = out_row + ROW_W'(1);
      // In 2x each source line is shown twice: advance only after odd rows.
      if (scale_mode == SCALE_1X || out_row[0]) nxt_line = line_base + LINE_STEP;
    end
    nxt_src = (nxt_scale == SCALE_2X) ? (nxt_col >> 1) : nxt_col;
  end

  // Request-side state advances only on pixel requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_col    <= '0;
      out_row    <= '0;
      line_base  <= '0;
      fb_base    <= '0;
      fb_sel_o   <= '0;
      scale_mode <= SCALE_1X;
      addrb_o    <= '0;
    end else if (bram_en_i) begin
      out_col    <= nxt_col;
      out_row    <= nxt_row;
      line_base  <= nxt_line;
      fb_base    <= nxt_fb_base;
      fb_sel_o   <= nxt_fb_sel;
      scale_mode <= nxt_scale;
      addrb_o    <= nxt_fb_base + nxt_line + ADDR_W'(nxt_src);
    end
  end

  // Swap request is held until consumed at the frame-end request.
  always_ff @(posedge clk) begin
    if (rst)                         swap_pend <= 1'b0;
    else if (bram_en_i && frame_end) swap_pend <= 1'b0;
    else if (fb_swap_i)              swap_pend <= 1'b1;
  end

  always_comb begin
    tag_in     = '0;
    tag_in.en  = bram_en_i;
    tag_in.sof = bram_en_i && (out_col == '0) && (out_row == '0);
    tag_in.eol = bram_en_i && line_end;
  end

  mem_rd_pipe #(.DEPTH(RD_LAT)) u_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (tag_in),
    .dout (tag_out)
  );

  assign RGB_en_o = tag_out.en;
  assign sof_o    = tag_out.sof;
  assign eol_o    = tag_out.eol;
  assign RGB_o    = tag_out.en ? mem2db_i : '0;

endmodule

// File: tb/tb_mem_rd_ctr.sv
// Scoreboard bench for mem_rd_ctr: a BRAM model with RD_LAT latency, a
// frame-position reference model, and a monitor that pops expected pixels.
module tb_mem_rd_ctr;

  localparam int unsigned MC     = 4;
  localparam int unsigned MR     = 4;
  localparam int unsigned DW     = 8;
  localparam int unsigned AW     = 20;
  localparam int unsigned NFB    = 2;
  parameter  int unsigned RD_LAT = 2;
  localparam int unsigned FBS    = MC * MR;
  localparam int unsigned MEM_AW = 5;
  localparam int unsigned MEM_N  = 1 << MEM_AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enb_o, web_o;
  logic [AW-1:0] addrb_o;
  logic [DW-1:0] d2memb_o, mem2db_i;
  logic          bram_en_i = 1'b0, fb_swap_i = 1'b0, scale_i = 1'b0;
  logic [0:0]    fb_sel_o;
  logic [DW-1:0] RGB_o;
  logic          RGB_en_o, sof_o, eol_o;

  mem_rd_ctr #(
    .MAX_COL(MC), .MAX_ROW(MR), .DATA_W(DW), .ADDR_W(AW), .NUM_FB(NFB), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .enb_o(enb_o), .web_o(web_o), .addrb_o(addrb_o),
    .d2memb_o(d2memb_o), .mem2db_i(mem2db_i), .bram_en_i(bram_en_i),
    .fb_swap_i(fb_swap_i), .scale_i(scale_i), .fb_sel_o(fb_sel_o),
    .RGB_o(RGB_o), .RGB_en_o(RGB_en_o), .sof_o(sof_o), .eol_o(eol_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: registered read through RD_LAT stages.
  logic [DW-1:0] mem [MEM_N];
  logic [DW-1:0] dq  [RD_LAT];
  always @(posedge clk) begin
    dq[0] <= enb_o ? mem[addrb_o[MEM_AW-1:0]] : DW'($urandom);
    for (int i = 1; i < int'(RD_LAT); i++) dq[i] <= dq[i-1];
  end
  assign mem2db_i = dq[RD_LAT-1];

  typedef struct {
    logic [DW-1:0] data;
    logic          sof;
    logic          eol;
    int            stamp;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every valid pixel must match the oldest outstanding request.
  always @(negedge clk) begin
    if (RGB_en_o) begin
      if (sb.size() == 0) begin
        chk("spurious_rgb_en", 32'(RGB_en_o), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rgb_data", 32'(RGB_o), 32'(e.data));
        chk("sof", 32'(sof_o), 32'(e.sof));
        chk("eol", 32'(eol_o), 32'(e.eol));
        chk("latency", 32'(cyc - e.stamp), 32'(RD_LAT));
      end
    end else begin
      chk("rgb_idle_zero", 32'(RGB_o), 32'd0);
    end
  end

  // Reference model: screen position, displayed buffer, pending swap, mode.
  int m_col, m_row, m_fb, m_pend, m_scale;

  function automatic int m_addr();
    if (m_scale != 0) return m_fb * FBS + (m_row / 2) * MC + m_col / 2;
    return m_fb * FBS + m_row * MC + m_col;
  endfunction

  function automatic int pix();
    return m_row * MC + m_col;
  endfunction

  task automatic model_reset();
    m_col = 0; m_row = 0; m_fb = 0; m_pend = 0; m_scale = 0;
  endtask

  task automatic step(input bit req, input bit swap, input bit scl);
    bit fend;
    exp_t e;
    @(negedge clk); #1;
    chk("fb_sel", 32'(fb_sel_o), 32'(m_fb));
    if (req) chk("addr", 32'(addrb_o), 32'(m_addr()));
    bram_en_i = req; fb_swap_i = swap; scale_i = scl;
    #1;
    chk("enb", 32'(enb_o), 32'(req));
    fend = (m_col == MC - 1) && (m_row == MR - 1);
    if (req) begin
      e.data  = mem[MEM_AW'(m_addr())];
      e.sof   = (m_col == 0) && (m_row == 0);
      e.eol   = (m_col == MC - 1);
      e.stamp = cyc;
      sb.push_back(e);
      if (fend) begin
        if (m_pend != 0 || swap) m_fb = (m_fb + 1) % NFB;
        m_pend  = 0;
        m_scale = scl ? 1 : 0;
        m_col = 0; m_row = 0;
      end else begin
        if (swap) m_pend = 1;
        if (m_col == MC - 1) begin m_col = 0; m_row++; end
        else m_col++;
      end
    end else if (swap) begin
      m_pend = 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1; bram_en_i = 1'b0; fb_swap_i = 1'b0; scale_i = 1'b0;
    sb.delete();
    @(negedge clk); #1;
    chk("rst_addr", 32'(addrb_o), 32'd0);
    chk("rst_rgb_en", 32'(RGB_en_o), 32'd0);
    chk("rst_rgb", 32'(RGB_o), 32'd0);
    chk("rst_sof", 32'(sof_o), 32'd0);
    chk("rst_eol", 32'(eol_o), 32'd0);
    chk("rst_fb_sel", 32'(fb_sel_o), 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic frame(input int swap_at, input int scl_from, input bit scl_val);
    for (int p = 0; p < int'(FBS); p++)
      step(1'b1, p == swap_at, (p >= scl_from) ? scl_val : ~scl_val);
  endtask

  initial begin
    int reqs;
    int guard;
    bit r, s;
    for (int i = 0; i < int'(MEM_N); i++) mem[i] = DW'($urandom);
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();
    chk("web_const", 32'(web_o), 32'd0);
    chk("wdata_const", 32'(d2memb_o), 32'd0);

    // Plain 1x frames, then a swap mid-frame, then a frame with no pulse.
    frame(-1, 0, 1'b0);
    frame(-1, 0, 1'b0);
    frame(5, 0, 1'b0);
    frame(-1, 0, 1'b0);
    chk("fb_after_swap", 32'(fb_sel_o), 32'd1);

    // Zoom requested mid-frame: applies from the next frame only.
    frame(-1, 6, 1'b1);
    frame(-1, 3, 1'b0);
    frame(-1, 0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Random gaps, random swap pulses and mode, swap on a frame-end request.
    reqs = 0;
    guard = 0;
    while (reqs < 3 * int'(FBS) && guard < 2000) begin
      r = ($urandom_range(0, 2) != 0);
      s = r && (m_col == MC - 1) && (m_row == MR - 1) && (reqs / int'(FBS) == 1);
      if (!s && $urandom_range(0, 24) == 0) s = 1'b1;
      step(r, s, 1'(($urandom_range(0, 1))));
      if (r) reqs++;
      guard++;
    end
    chk("random_phase_done", 32'(reqs), 32'(3 * FBS));

    // Reach pixel 9 on buffer 1 with a swap pending, then reset.
    guard = 0;
    while (!(m_fb == 1 && pix() == 9 && m_pend != 0) && guard < 200) begin
      step(1'b1, pix() == 2, 1'b0);
      guard++;
    end
    chk("pre_reset_state", 32'(m_fb == 1 && pix() == 9 && m_pend != 0), 32'd1);
    do_reset();
    frame(-1, 0, 1'b0);
    frame(-1, 0, 1'b0);

    repeat (RD_LAT + 3) step(1'b0, 1'b0, 1'b0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_rd_ctr.md
Name: mem_rd_ctr

Overview:
- Parametrised BRAM port-B frame reader feeding the VGA pixel path.
- Each pixel request from VGA timing generates one read address; returned data is re-aligned to a configurable BRAM read latency.
- Adds multi-buffer (page-flip) display with swap applied only at frame boundaries, and a 1x/2x pixel-replication zoom mode.
- Emits start-of-frame and end-of-line markers aligned with the pixel data.

Parameters:
- MAX_COL, 540, displayed pixels per line; must be even.
- MAX_ROW, 540, displayed lines per frame; must be even.
- DATA_W, 8, pixel width in bits.
- ADDR_W, 20, BRAM address width; must satisfy NUM_FB*MAX_COL*MAX_ROW <= 2**ADDR_W.
- NUM_FB, 2, number of frame buffers stored back-to-back in BRAM. Buffer k base = k*MAX_COL*MAX_ROW.
- RD_LAT, 2, BRAM read latency in cycles; range 1..4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- enb_o  out  1  BRAM port-B enable
- web_o  out  1  BRAM write enable; constant 0
- addrb_o  out  ADDR_W  BRAM read address
- d2memb_o  out  DATA_W  BRAM write data; constant 0
- mem2db_i  in  DATA_W  BRAM read data
- bram_en_i  in  1  pixel request from VGA timing, one per displayed pixel
- fb_swap_i  in  1  single-cycle pulse: display next buffer from the next frame
- scale_i  in  1  zoom mode: 0 = 1x, 1 = 2x
- fb_sel_o  out  $clog2(NUM_FB) (min 1)  index of the buffer currently being read
- RGB_o  out  DATA_W  pixel data
- RGB_en_o  out  1  pixel valid
- sof_o  out  1  first pixel of frame; qualified by RGB_en_o
- eol_o  out  1  last pixel of line; qualified by RGB_en_o

Behaviour:
- Reset (rst=1 at a clk edge):
  - Counters, line base, fb_sel_o, pending swap, latched mode and the whole delay pipeline clear to 0.
  - addrb_o=0, RGB_en_o=0, RGB_o=0, sof_o=0, eol_o=0.
  - Reset mid-frame abandons the frame; the next request is pixel (0,0) of buffer 0.
- Request side:
  - enb_o = bram_en_i (combinational). addrb_o is a register holding the address of the current pixel.
  - On each clk edge with bram_en_i=1, col/row counters and the address advance to the next pixel.
  - No advance when bram_en_i=0; gaps of any length are legal.
- Counters:
  - out_col runs 0..MAX_COL-1. On wrap, out_row increments (0..MAX_ROW-1).
  - The frame ends at (MAX_COL-1, MAX_ROW-1), which wraps to (0,0).
- Address:
  - addr = fb_base + line_base + src_col.
  - 1x: src_col = out_col. line_base advances by MAX_COL every line.
  - 2x: src_col = out_col>>1. line_base advances by MAX_COL only after odd out_row, so each source line is read twice. The source window is the top-left (MAX_COL/2 x MAX_ROW/2) of the buffer.
  - Implement with adders only, no multipliers. fb_base is a register stepped by MAX_COL*MAX_ROW.
- Mode latching: scale_i is sampled only at the frame-end request edge (and at reset, to 0). Changes mid-frame are ignored until the next frame.
- Buffer swap:
  - fb_swap_i sets a pending flag.
  - At the frame-end request edge, if pending (or fb_swap_i is high in that same cycle), fb_sel_o increments modulo NUM_FB and pending clears.
  - Multiple pulses within one frame produce a single swap.
  - With NUM_FB=1, swap is a no-op.
- Data side:
  - {en, sof, eol} pass through an RD_LAT-deep register pipeline driven by bram_en_i.
  - sof = request at (0,0); eol = request at out_col=MAX_COL-1.
  - RGB_en_o, sof_o and eol_o are the pipeline outputs.
  - RGB_o = mem2db_i when RGB_en_o=1, else 0.
  - Latency: request at edge N yields RGB_en_o=1 during cycle N+RD_LAT.

Decomposition:
- Package mem_rd_pkg holds:
  - enum scale_mode_t {SCALE_1X, SCALE_2X};
  - typedef pipe_tag_t struct {en, sof, eol};
  - function for buffer base/size constants.
- Sub-module mem_rd_pipe: parametrised RD_LAT-deep shift register of pipe_tag_t with synchronous active-high clear.

Test Plan (MAX_COL=4, MAX_ROW=4, NUM_FB=2, RD_LAT=2 unless noted):
- Reset, then 16 continuous requests, 1x -> addrb_o 0..15. RGB_en_o high 2 cycles after the first request. sof_o on pixel 0; eol_o on pixels 3,7,11,15. Next frame restarts at 0.
- fb_swap_i pulse at pixel 5, then run on -> fb_sel_o goes 0→1 at the frame-end edge. Next frame addresses 16..31. A second frame with no pulse stays on 16..31.
- scale_i=1 set mid-frame -> current frame stays 1x. Next frame addresses are 0,0,1,1 | 0,0,1,1 | 4,4,5,5 | 4,4,5,5.
- Requests with random gaps, plus fb_swap_i asserted exactly on the frame-end request -> address sequence identical to the gapless run, RGB_en_o count equals request count, swap takes effect immediately.
- rst asserted at pixel 9 while fb_sel_o=1 with a swap pending -> all outputs 0 the next cycle, pipeline flushed (no stale RGB_en_o), restart at address 0 with fb_sel_o=0.
- RD_LAT=1 and RD_LAT=4 builds -> RGB_en_o/sof_o lag requests by exactly 1 and 4 cycles; data in RGB_o matches the BRAM model contents.
